// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: grant states, master ids and the tie-break helper for the memory arbiter.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT_IF, ARB_GRANT_LSM} arb_state_e;
    localparam logic ARB_MASTER_IF = 1'b0;
    localparam logic ARB_MASTER_LSM = 1'b1;
    // On a tie the master that was not granted last wins, unless load-store has fixed priority.
    function automatic arb_state_e arb_rr_pick(input logic if_req, input logic lsm_req, input logic lsm_prio, input logic last);
        return (if_req && lsm_req) ? ((lsm_prio || last == ARB_MASTER_IF) ? ARB_GRANT_LSM : ARB_GRANT_IF)
             : if_req ? ARB_GRANT_IF : lsm_req ? ARB_GRANT_LSM : ARB_IDLE;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one Wishbone B4 pipelined link; master drives the request, slave answers.
interface mem_arbiter_if;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        stall;
    modport master (output adr, wdat, sel, we, stb, cyc, input rdat, ack, stall);
    modport slave (input adr, wdat, sel, we, stb, cyc, output rdat, ack, stall);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (fetch, load-store) to one-slave Wishbone pipelined arbiter
// holding the grant for a whole cyc and capping accepted-but-unacknowledged requests.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit          LSM_PRIORITY    = 1'b0,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic            clk_i,
    input logic            rst_ni,
    mem_arbiter_if.slave   if_bus,
    mem_arbiter_if.slave   lsm_bus,
    mem_arbiter_if.master  wb_bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    arb_state_e    state_q, state_d;
    logic          last_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          g_if, g_lsm, own_cyc, full, inc, dec;

    always_comb begin
        g_if = state_q == ARB_GRANT_IF;
        g_lsm = state_q == ARB_GRANT_LSM;
        own_cyc = (g_if & if_bus.cyc) | (g_lsm & lsm_bus.cyc);
        full = cnt_q == MAX_CNT;
        state_d = own_cyc ? state_q : arb_rr_pick(if_bus.cyc, lsm_bus.cyc, LSM_PRIORITY, last_q);
        wb_bus.adr = g_if ? if_bus.adr : g_lsm ? lsm_bus.adr : '0;
        wb_bus.wdat = g_if ? if_bus.wdat : g_lsm ? lsm_bus.wdat : '0;
        wb_bus.sel = g_if ? if_bus.sel : g_lsm ? lsm_bus.sel : '0;
        wb_bus.we = g_if ? if_bus.we : g_lsm & lsm_bus.we;
        wb_bus.cyc = own_cyc;
        wb_bus.stb = ((g_if & if_bus.stb) | (g_lsm & lsm_bus.stb)) & ~full;
        if_bus.stall = ~g_if | wb_bus.stall | full;
        lsm_bus.stall = ~g_lsm | wb_bus.stall | full;
        if_bus.ack = g_if & wb_bus.ack;
        lsm_bus.ack = g_lsm & wb_bus.ack;
        if_bus.rdat = wb_bus.rdat;
        lsm_bus.rdat = wb_bus.rdat;
        inc = wb_bus.stb & ~wb_bus.stall;
        dec = wb_bus.ack & (cnt_q != '0);
        // Dropping cyc aborts the cycle, so any grant change forgets what was outstanding.
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(inc) - CW'(dec);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            last_q <= ARB_MASTER_LSM;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            if (state_d != state_q && state_d != ARB_IDLE) last_q <= state_d == ARB_GRANT_LSM;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: round-robin and load-store-priority arbiters run side by side on shared
// stimulus and are checked every cycle against an owner/count model plus literal expectations.
module tb_mem_arbiter;
    localparam int MAXO = 2;

    typedef struct packed {
        logic        cyc, stb, we;
        logic [3:0]  sel;
        logic [31:0] adr, wd, rd_if, rd_ls;
        logic        if_stall, ls_stall, if_ack, ls_ack;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] i_adr = '0, i_wd = '0, l_adr = '0, l_wd = '0, s_rdat = '0;
    logic [3:0]  i_sel = '0, l_sel = '0;
    logic        i_we = 0, i_stb = 0, i_cyc = 0, l_we = 0, l_stb = 0, l_cyc = 0;
    logic        s_ack = 0, s_stall = 0;
    int          n_cmp = 0, n_bad = 0;

    mem_arbiter_if if0(), ls0(), wb0(), if1(), ls1(), wb1();
    assign if0.adr = i_adr, if0.wdat = i_wd, if0.we = i_we, if0.sel = i_sel, if0.stb = i_stb, if0.cyc = i_cyc;
    assign if1.adr = i_adr, if1.wdat = i_wd, if1.we = i_we, if1.sel = i_sel, if1.stb = i_stb, if1.cyc = i_cyc;
    assign ls0.adr = l_adr, ls0.wdat = l_wd, ls0.we = l_we, ls0.sel = l_sel, ls0.stb = l_stb, ls0.cyc = l_cyc;
    assign ls1.adr = l_adr, ls1.wdat = l_wd, ls1.we = l_we, ls1.sel = l_sel, ls1.stb = l_stb, ls1.cyc = l_cyc;
    assign wb0.rdat = s_rdat, wb0.ack = s_ack, wb0.stall = s_stall;
    assign wb1.rdat = s_rdat, wb1.ack = s_ack, wb1.stall = s_stall;

    mem_arbiter #(.LSM_PRIORITY(1'b0), .MAX_OUTSTANDING(MAXO)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .if_bus(if0), .lsm_bus(ls0), .wb_bus(wb0));
    mem_arbiter #(.LSM_PRIORITY(1'b1), .MAX_OUTSTANDING(MAXO)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .if_bus(if1), .lsm_bus(ls1), .wb_bus(wb1));

    obs_t o [2];
    assign o[0] = '{cyc: wb0.cyc, stb: wb0.stb, we: wb0.we, sel: wb0.sel, adr: wb0.adr, wd: wb0.wdat,
                    rd_if: if0.rdat, rd_ls: ls0.rdat, if_stall: if0.stall, ls_stall: ls0.stall,
                    if_ack: if0.ack, ls_ack: ls0.ack};
    assign o[1] = '{cyc: wb1.cyc, stb: wb1.stb, we: wb1.we, sel: wb1.sel, adr: wb1.adr, wd: wb1.wdat,
                    rd_if: if1.rdat, rd_ls: ls1.rdat, if_stall: if1.stall, ls_stall: ls1.stall,
                    if_ack: if1.ack, ls_ack: ls1.ack};

    // Model state: owner 0 = nobody, 1 = fetch, 2 = load-store; cnt = requests awaiting ack.
    int own [2] = '{0, 0};
    int last [2] = '{2, 2};
    int cnt [2] = '{0, 0};

    task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] x);
        n_cmp++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, a, x);
        end
    endtask

    task automatic chk1(input string nm, input logic a, input logic x);
        n_cmp++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", nm, a, x);
        end
    endtask

    function automatic obs_t mexp(input int d);
        obs_t e;
        e = '0;
        e.rd_if = s_rdat;
        e.rd_ls = s_rdat;
        e.if_stall = 1'b1;
        e.ls_stall = 1'b1;
        if (own[d] == 1) begin
            e.adr = i_adr; e.wd = i_wd; e.we = i_we; e.sel = i_sel; e.cyc = i_cyc;
            e.stb = i_stb && cnt[d] < MAXO;
            e.if_stall = s_stall || cnt[d] == MAXO;
            e.if_ack = s_ack;
        end else if (own[d] == 2) begin
            e.adr = l_adr; e.wd = l_wd; e.we = l_we; e.sel = l_sel; e.cyc = l_cyc;
            e.stb = l_stb && cnt[d] < MAXO;
            e.ls_stall = s_stall || cnt[d] == MAXO;
            e.ls_ack = s_ack;
        end
        return e;
    endfunction

    task automatic cmp(input int d, input obs_t a, input obs_t x);
        string p;
        p = $sformatf("dut%0d.", d);
        chk1({p, "wb_cyc"}, a.cyc, x.cyc);
        chk1({p, "wb_stb"}, a.stb, x.stb);
        chk1({p, "wb_we"}, a.we, x.we);
        chk32({p, "wb_sel"}, {28'd0, a.sel}, {28'd0, x.sel});
        chk32({p, "wb_adr"}, a.adr, x.adr);
        chk32({p, "wb_dat"}, a.wd, x.wd);
        chk32({p, "if_dat"}, a.rd_if, x.rd_if);
        chk32({p, "lsm_dat"}, a.rd_ls, x.rd_ls);
        chk1({p, "if_stall"}, a.if_stall, x.if_stall);
        chk1({p, "lsm_stall"}, a.ls_stall, x.ls_stall);
        chk1({p, "if_ack"}, a.if_ack, x.if_ack);
        chk1({p, "lsm_ack"}, a.ls_ack, x.ls_ack);
    endtask

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) cmp(d, o[d], mexp(d));
    end

    initial forever begin
        obs_t e;
        int w, oc;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            own = '{0, 0};
            last = '{2, 2};
            cnt = '{0, 0};
        end else begin
            for (int d = 0; d < 2; d++) begin
                e = mexp(d);
                oc = own[d] == 1 ? int'(i_cyc) : own[d] == 2 ? int'(l_cyc) : 0;
                if (own[d] != 0 && oc != 0) begin
                    cnt[d] = cnt[d] + ((e.stb && !s_stall) ? 1 : 0) - ((s_ack && cnt[d] > 0) ? 1 : 0);
                end else begin
                    w = (i_cyc && l_cyc) ? ((d == 1 || last[d] == 1) ? 2 : 1) : i_cyc ? 1 : l_cyc ? 2 : 0;
                    own[d] = w;
                    cnt[d] = 0;
                    if (w != 0) last[d] = w;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2 chk1("rst.wb_cyc0", wb0.cyc, 1'b0); chk1("rst.if_stall0", if0.stall, 1'b1); chk1("rst.lsm_stall1", ls1.stall, 1'b1);
        tick();
        // simultaneous requests from reset
        i_cyc = 1; i_stb = 1; i_adr = 32'h200; i_sel = 4'hf;
        l_cyc = 1; l_stb = 1; l_adr = 32'h300; l_sel = 4'h3; l_we = 1; l_wd = 32'h55;
        #2 chk1("tie.req_stall0", if0.stall, 1'b1); chk1("tie.req_cyc1", wb1.cyc, 1'b0);
        tick();
        #2 chk32("tie.rr_adr0", wb0.adr, 32'h200); chk1("tie.rr_lsm_stall0", ls0.stall, 1'b1);
        chk32("tie.prio_adr1", wb1.adr, 32'h300); chk1("tie.prio_we1", wb1.we, 1'b1);
        tick();
        i_cyc = 0; i_stb = 0;
        #2 chk1("tie.drop_cyc0", wb0.cyc, 1'b0);
        tick();
        #2 chk32("tie.handover_adr0", wb0.adr, 32'h300); chk1("tie.handover_cyc0", wb0.cyc, 1'b1);
        chk1("lim.stb1", wb1.stb, 1'b0); chk1("lim.stall1", ls1.stall, 1'b1);
        tick();
        l_cyc = 0; l_stb = 0;
        tick();
        i_cyc = 1; i_stb = 1; l_cyc = 1; l_stb = 1;
        tick();
        i_cyc = 0; i_stb = 0; l_cyc = 0; l_stb = 0;
        #2 chk32("tie2.rr_adr0", wb0.adr, 32'h200); chk32("tie2.prio_adr1", wb1.adr, 32'h300);
        tick();
        tick();
        // single fetch read with one slave stall
        i_cyc = 1; i_stb = 1; i_adr = 32'h100; l_we = 0;
        tick();
        s_stall = 1;
        #2 chk32("rd.adr0", wb0.adr, 32'h100); chk1("rd.stb0", wb0.stb, 1'b1); chk1("rd.stall0", if0.stall, 1'b1);
        tick();
        s_stall = 0;
        #2 chk1("rd.accept0", if0.stall, 1'b0);
        tick();
        i_stb = 0;
        tick();
        s_ack = 1; s_rdat = 32'hDEADBEEF;
        #2 chk1("rd.ack0", if0.ack, 1'b1); chk32("rd.dat0", if0.rdat, 32'hDEADBEEF); chk1("rd.lsm_ack0", ls0.ack, 1'b0);
        chk1("rd.ack1", if1.ack, 1'b1); chk1("rd.lsm_ack1", ls1.ack, 1'b0);
        tick();
        s_ack = 0; i_cyc = 0;
        tick();
        tick();
        // outstanding limit, then an ack coinciding with hand-over
        i_cyc = 1; i_stb = 1; i_adr = 32'h400;
        tick();
        tick();
        #2 chk1("out.second0", wb0.stb, 1'b1);
        tick();
        #2 chk1("out.full_stb0", wb0.stb, 1'b0); chk1("out.full_stall0", if0.stall, 1'b1);
        tick();
        s_ack = 1;
        #2 chk1("out.ack0", if0.ack, 1'b1); chk1("out.ack_stb0", wb0.stb, 1'b0);
        tick();
        s_ack = 0;
        #2 chk1("out.third0", wb0.stb, 1'b1); chk1("out.third_stall0", if0.stall, 1'b0);
        tick();
        i_cyc = 0; i_stb = 0; s_ack = 1; l_cyc = 1; l_stb = 1; l_adr = 32'h600;
        #2 chk1("ho.old_ack0", if0.ack, 1'b1); chk1("ho.new_ack0", ls0.ack, 1'b0);
        tick();
        s_ack = 0;
        #2 chk1("ho.lsm_ack0", ls0.ack, 1'b0); chk32("ho.adr0", wb0.adr, 32'h600); chk1("ho.cnt0_stb0", wb0.stb, 1'b1);
        tick();
        #2 chk1("ho.cnt1_stb0", wb0.stb, 1'b1);
        tick();
        l_cyc = 0; l_stb = 0;
        tick();
        s_ack = 1;
        #2 chk1("stray.if_ack0", if0.ack, 1'b0); chk1("stray.lsm_ack0", ls0.ack, 1'b0); chk1("stray.lsm_ack1", ls1.ack, 1'b0);
        tick();
        s_ack = 0;
        tick();
        // asynchronous reset in the middle of a grant
        i_cyc = 1; i_stb = 1; i_adr = 32'h500;
        tick();
        #1 chk1("ares.cyc_before0", wb0.cyc, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk1("ares.cyc0", wb0.cyc, 1'b0); chk1("ares.stb0", wb0.stb, 1'b0);
        chk1("ares.if_stall0", if0.stall, 1'b1); chk1("ares.lsm_stall0", ls0.stall, 1'b1); chk1("ares.cyc1", wb1.cyc, 1'b0);
        tick();
        rst_n = 1'b1;
        #2 chk1("ares.idle_cyc0", wb0.cyc, 1'b0);
        tick();
        #2 chk1("ares.regrant_cyc0", wb0.cyc, 1'b1); chk1("ares.regrant_stb0", wb0.stb, 1'b1);
        tick();
        tick();
        i_cyc = 0; i_stb = 0;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
